gpr_wb_arbiter: RTL

- Shares the single GPR write port (RegWr/Rw/busW) between two writeback requesters: ALU path (req0) and load/CSR path (req1).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered drive of the GPR write port.
- 32-entry busy scoreboard: the issue stage sets pending-destination bits; the decode stage queries them for Ra/Rb hazard detection.

---
 rtl/gpr_wb_arbiter_if.sv | 31 +++
 rtl/gpr_wb_arbiter.sv | 61 ++++++
 2 files changed

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: writeback requesters, GPR write port and busy scoreboard signals of gpr_wb_arbiter
interface gpr_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                     req0_valid, req0_ready;
    logic [ADDR_W-1:0]        req0_rd;
    logic [DATA_W-1:0]        req0_data;
    logic                     req1_valid, req1_ready;
    logic [ADDR_W-1:0]        req1_rd;
    logic [DATA_W-1:0]        req1_data;
    logic                     RegWr;
    logic [ADDR_W-1:0]        Rw;
    logic [DATA_W-1:0]        busW;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_rd;
    logic                     flush;
    logic [ADDR_W-1:0]        q_ra, q_rb;
    logic                     q_busy_a, q_busy_b;
    logic [(1<<ADDR_W)-1:0]   busy_vec;
    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        input  iss_valid, iss_rd, flush, q_ra, q_rb,
        output req0_ready, req1_ready, RegWr, Rw, busW, q_busy_a, q_busy_b, busy_vec
    );
    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        output iss_valid, iss_rd, flush, q_ra, q_rb,
        input  req0_ready, req1_ready, RegWr, Rw, busW, q_busy_a, q_busy_b, busy_vec
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin arbiter sharing the GPR write port, with a pending-destination scoreboard
// Define GPR_WB_ARB_TRACE_EN to print a simulation trace of GPR writes and contention cycles.
module gpr_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic clk,
    input logic rst_n,
    gpr_wb_arbiter_if.slave bus
);
    localparam int ENT = 1 << ADDR_W;
    logic              lastGrant, grant0, grant1, accAny;
    logic [ADDR_W-1:0] accRd;
    logic [DATA_W-1:0] accData;
    logic [ENT-1:0]    busy, busyNext, setMask, clrMask;
    always_comb begin
        grant0   = rst_n & bus.req0_valid & (~bus.req1_valid | lastGrant);
        grant1   = rst_n & bus.req1_valid & (~bus.req0_valid | ~lastGrant);
        accAny   = grant0 | grant1;
        accRd    = grant0 ? bus.req0_rd : bus.req1_rd;
        accData  = grant0 ? bus.req0_data : bus.req1_data;
        setMask  = bus.iss_valid ? ENT'(1) << bus.iss_rd : '0;
        clrMask  = accAny ? ENT'(1) << accRd : '0;
        // a new producer's set overrides a retiring write's clear; r0 never goes busy
        busyNext = bus.flush ? '0 : ((busy & ~clrMask) | setMask) & ~ENT'(1);
    end
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.busy_vec   = busy;
    assign bus.q_busy_a   = busy[bus.q_ra];
    assign bus.q_busy_b   = busy[bus.q_rb];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.RegWr <= 1'b0;
            bus.Rw    <= '0;
            bus.busW  <= '0;
            lastGrant <= 1'b1;
            busy      <= '0;
        end else begin
            bus.RegWr <= accAny && accRd != '0;
            if (accAny && accRd != '0) begin
                bus.Rw   <= accRd;
                bus.busW <= accData;
            end
            if (accAny) lastGrant <= grant1;
            busy <= busyNext;
        end
    end
`ifdef GPR_WB_ARB_TRACE_EN
    logic [31:0] cycleCnt;
    logic        lastWinner;
    always_ff @(posedge clk) begin
        cycleCnt   <= rst_n ? cycleCnt + 1 : '0;
        lastWinner <= grant1;
        if (rst_n && bus.RegWr)
            $display("[%0d] GPR write Rw=%0d busW=%h from req%0d", cycleCnt, bus.Rw, bus.busW, lastWinner);
        if (rst_n && bus.req0_valid && bus.req1_valid)
            $display("[%0d] contention: req%0d waits", cycleCnt, grant0);
    end
`endif
endmodule
